nids_inst_encoder: RTL
======================

Name: nids_inst_encoder

Overview:
Program loader for the NIDS core, and the inverse of the core's instruction decoder. It accepts compact command records over a valid/ready handshake, encodes each record into a 32-bit RV32-style instruction word, and writes the words sequentially into instruction memory. The supported encodings include the pattern-load extension (LD with funct3=001, pattern address in bits [31:27]) and the halt word (opcode 7'b1111111, funct3=000). It sits between the host configuration path and the core's imem write port.

Parameters:
AW, 6, imem address width; program capacity DEPTH = 2**AW words.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: clear pointer/flags and begin a new program
- cmd_valid  in  1  command record valid
- cmd_ready  out  1  encoder can accept a record
- cmd_type  in  4  0 R-R, 1 R-I, 2 LD, 3 SD, 4 LUI, 5 BRANCH, 6 JAL, 7 JALR, 8 PATTERN_LD, 9 HALT
- cmd_alu  in  4  ALU code for R-R/R-I (0 add, 1 sub, 2 or, 3 and, 6 sll, 7 srl); for BRANCH, cmd_alu[2:0] is the branch funct3
- cmd_rd  in  5  destination register
- cmd_rs1  in  5  source register 1
- cmd_rs2  in  5  source register 2
- cmd_imm  in  21  immediate (signed where the format is signed); for PATTERN_LD, cmd_imm[4:0] is the pattern address
- cmd_last  in  1  final record of the program
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  AW  write address
- imem_wdata  out  32  encoded instruction word
- prog_done  out  1  program complete
- prog_len  out  AW+1  number of words written, including halt
- err_illegal  out  1  sticky: illegal command dropped
- err_overflow  out  1  sticky: capacity exceeded

Behaviour:
- Reset: all outputs 0; wr_ptr=0; FSM in IDLE.
- FSM states: IDLE, ACCEPT, WRITE, HALT, DONE.
- IDLE: cmd_ready=0. start -> ACCEPT, with wr_ptr, prog_len, error flags and prog_done cleared.
- ACCEPT: cmd_ready=1. The record is captured when cmd_valid&cmd_ready; next state is WRITE.
- WRITE (exactly 1 cycle after acceptance): imem_we=1, imem_addr=wr_ptr, imem_wdata=encoded word; wr_ptr++. Next state is HALT if the captured cmd_last (and AUTO_HALT_EN), otherwise DONE if the captured type was HALT, otherwise ACCEPT. cmd_ready=0 in this state, so maximum throughput is 1 word per 2 cycles.
- HALT: writes 32'h0000007F at wr_ptr, increments, then goes to DONE.
- DONE: prog_done=1 and prog_len=wr_ptr, both held. start -> ACCEPT with a fresh program; all other inputs are ignored.
- start in ACCEPT/WRITE/HALT restarts the program (pointer back to 0). Any in-flight write in that cycle is suppressed.
- Encoding (opcode / funct3 / funct7):
  - R-R: 0110011; funct3 from cmd_alu (0/1->000, 6->001, 7->101, 2->110, 3->111); funct7=0100000 only for sub, else 0.
  - R-I: 0010011, same funct3 map; imm[11:0]->[31:20]. For sll/srl, [31:25]=0 and shamt=cmd_imm[4:0].
  - LD: 0000011, funct3=010, I-format.
  - PATTERN_LD: 0000011, funct3=001, [31:27]=cmd_imm[4:0], [26:20]=0.
  - SD: 0100011, funct3=010, S-format split imm.
  - LUI: 0110111, cmd_imm[19:0]->[31:12].
  - BRANCH: 1100011, B-format from cmd_imm[12:1].
  - JAL: 1101111, J-format from cmd_imm[20:1].
  - JALR: 1100111, funct3=000, I-format.
  - HALT: 32'h0000007F.
- Illegal records: cmd_type>9, cmd_alu not in {0,1,2,3,6,7} for R-R/R-I, sub with R-I, or branch funct3 in {010,011}. Illegal records are accepted but not written; err_illegal is set and the FSM returns to ACCEPT.
- Overflow: address DEPTH-1 is reserved for halt. A non-HALT record accepted when wr_ptr==DEPTH-1 sets err_overflow, is not written, and forces the HALT state, then DONE.
- Simultaneous cmd_valid and start: start wins and the record is not accepted.

Optional Feature:
AUTO_HALT_EN:
- Defined: cmd_last causes the halt word to be appended automatically after the last record's write.
- Undefined: cmd_last is ignored, and only an explicit HALT record (or overflow) ends the program.

Test Plan:
- start; R-R sub rd=3 rs1=1 rs2=2 -> imem_we at addr 0, wdata 32'h402081B3, one cycle after the handshake.
- R-I add rd=1 rs1=0 imm=10 with cmd_last, AUTO_HALT_EN on -> addr0=32'h00A00093, addr1=32'h0000007F, prog_done=1, prog_len=2.
- PATTERN_LD rd=5 rs1=0 imm=3 -> 32'h18001283.
- R-I with cmd_alu=1 -> no write, err_illegal=1; the next valid record is still written at addr 0.
- AW=2: feed 4 R-R records -> words at addr 0..2, 4th record dropped, halt at addr 3, err_overflow=1, prog_len=4.
- Assert rst_n low during the WRITE cycle -> imem_we=0 immediately, all outputs 0; after release, start rewrites from addr 0.

Source files
------------

// File: rtl/nids_inst_encoder.sv
// -----------------------------------------------------------------------------
// nids_inst_encoder
//
// Program loader for the NIDS core. Accepts compact command records over a
// valid/ready handshake, encodes each one into a 32-bit RV32-style
// instruction word (the inverse of the core's decoder, including the
// pattern-load extension and the halt word), and writes the words into
// sequential instruction-memory addresses starting at 0.
//
// Build option:
//   AUTO_HALT_EN  when defined, a record flagged cmd_last is followed
//                 automatically by a halt word. When undefined, cmd_last
//                 is ignored and only an explicit HALT record, or an
//                 overflow, ends the program.
//
// Parameters:
//   AW            imem address width; program capacity is 2**AW words.
//                 The top address is reserved for the halt word.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle pulse: restart from address 0, clear status
//   cmd_valid     command record valid
//   cmd_ready     encoder can accept a record this cycle
//   cmd_type      0 R-R, 1 R-I, 2 LD, 3 SD, 4 LUI, 5 BRANCH, 6 JAL,
//                 7 JALR, 8 PATTERN_LD, 9 HALT
//   cmd_alu       ALU code (0 add, 1 sub, 2 or, 3 and, 6 sll, 7 srl);
//                 branch funct3 in [2:0] for BRANCH
//   cmd_rd/rs1/rs2 register fields
//   cmd_imm       immediate; pattern address in [4:0] for PATTERN_LD
//   cmd_last      final record of the program
//   imem_we/addr/wdata  instruction-memory write port
//   prog_done     program complete (held until the next start)
//   prog_len      words written, including the halt word
//   err_illegal   sticky: an illegal record was dropped
//   err_overflow  sticky: a record did not fit before the halt slot
// -----------------------------------------------------------------------------
module nids_inst_encoder #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_type,
  input  logic [3:0]    cmd_alu,
  input  logic [4:0]    cmd_rd,
  input  logic [4:0]    cmd_rs1,
  input  logic [4:0]    cmd_rs2,
  input  logic [20:0]   cmd_imm,
  input  logic          cmd_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          prog_done,
  output logic [AW:0]   prog_len,
  output logic          err_illegal,
  output logic          err_overflow
);

`ifdef AUTO_HALT_EN
  localparam logic AUTO_HALT = 1'b1;
`else
  localparam logic AUTO_HALT = 1'b0;
`endif

  localparam logic [6:0]  OP_RR     = 7'b0110011;
  localparam logic [6:0]  OP_RI     = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [31:0] HALT_WORD = 32'h0000007F;

  // Highest address; only a halt word may be written here.
  localparam logic [AW:0] LAST_SLOT = {1'b0, {AW{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_HALT,
    S_DONE
  } state_t;

  state_t       state_reg, state_next;
  logic [AW:0]  wr_ptr_reg, wr_ptr_next;     // one extra bit so DEPTH is representable
  logic [31:0]  word_reg, word_next;
  logic         last_reg, last_next;
  logic         halt_reg, halt_next;
  logic [AW:0]  prog_len_reg, prog_len_next;
  logic         err_illegal_reg, err_illegal_next;
  logic         err_overflow_reg, err_overflow_next;

  // ---------------------------------------------------------------------------
  // Record encoder (purely combinational on the command inputs)
  // ---------------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        enc_halt;
  logic [2:0]  alu_f3;
  logic        alu_ok;
  logic        alu_shift;

  always_comb begin
    alu_f3 = 3'b000;
    alu_ok = 1'b1;
    unique case (cmd_alu)
      4'd0, 4'd1: alu_f3 = 3'b000;
      4'd2:       alu_f3 = 3'b110;
      4'd3:       alu_f3 = 3'b111;
      4'd6:       alu_f3 = 3'b001;
      4'd7:       alu_f3 = 3'b101;
      default:    alu_ok = 1'b0;
    endcase
  end

  assign alu_shift = (cmd_alu == 4'd6) || (cmd_alu == 4'd7);

  always_comb begin
    enc_word    = 32'h0;
    enc_illegal = 1'b0;
    enc_halt    = 1'b0;
    unique case (cmd_type)
      4'd0: begin // R-R
        enc_illegal = !alu_ok;
        enc_word = {(cmd_alu == 4'd1) ? 7'b0100000 : 7'b0000000,
                    cmd_rs2, cmd_rs1, alu_f3, cmd_rd, OP_RR};
      end
      4'd1: begin // R-I; there is no subtract-immediate
        enc_illegal = !alu_ok || (cmd_alu == 4'd1);
        if (alu_shift)
          enc_word = {7'b0000000, cmd_imm[4:0], cmd_rs1, alu_f3, cmd_rd, OP_RI};
        else
          enc_word = {cmd_imm[11:0], cmd_rs1, alu_f3, cmd_rd, OP_RI};
      end
      4'd2: begin // LD
        enc_word = {cmd_imm[11:0], cmd_rs1, 3'b010, cmd_rd, OP_LOAD};
      end
      4'd3: begin // SD
        enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, 3'b010, cmd_imm[4:0], OP_STORE};
      end
      4'd4: begin // LUI
        enc_word = {cmd_imm[19:0], cmd_rd, OP_LUI};
      end
      4'd5: begin // BRANCH; funct3 010/011 are unassigned
        enc_illegal = (cmd_alu[2:1] == 2'b01);
        enc_word = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_alu[2:0],
                    cmd_imm[4:1], cmd_imm[11], OP_BRANCH};
      end
      4'd6: begin // JAL
        enc_word = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12],
                    cmd_rd, OP_JAL};
      end
      4'd7: begin // JALR
        enc_word = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, OP_JALR};
      end
      4'd8: begin // PATTERN_LD: pattern address lives in the top five bits
        enc_word = {cmd_imm[4:0], 7'b0000000, cmd_rs1, 3'b001, cmd_rd, OP_LOAD};
      end
      4'd9: begin // HALT
        enc_halt = 1'b1;
        enc_word = HALT_WORD;
      end
      default: enc_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Loader FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      wr_ptr_reg       <= '0;
      word_reg         <= '0;
      last_reg         <= 1'b0;
      halt_reg         <= 1'b0;
      prog_len_reg     <= '0;
      err_illegal_reg  <= 1'b0;
      err_overflow_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      wr_ptr_reg       <= wr_ptr_next;
      word_reg         <= word_next;
      last_reg         <= last_next;
      halt_reg         <= halt_next;
      prog_len_reg     <= prog_len_next;
      err_illegal_reg  <= err_illegal_next;
      err_overflow_reg <= err_overflow_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    wr_ptr_next       = wr_ptr_reg;
    word_next         = word_reg;
    last_next         = last_reg;
    halt_next         = halt_reg;
    prog_len_next     = prog_len_reg;
    err_illegal_next  = err_illegal_reg;
    err_overflow_next = err_overflow_reg;
    cmd_ready         = 1'b0;
    imem_we           = 1'b0;
    imem_wdata        = 32'h0;

    if (start) begin
      // Restart from any state. Strobes stay low, which also suppresses a
      // write that would otherwise land in this cycle, and cmd_ready stays
      // low so a coincident record is never accepted.
      state_next        = S_ACCEPT;
      wr_ptr_next       = '0;
      prog_len_next     = '0;
      err_illegal_next  = 1'b0;
      err_overflow_next = 1'b0;
    end else begin
      unique case (state_reg)
        S_IDLE: ;

        S_ACCEPT: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            if (enc_illegal) begin
              // Dropped without consuming an address.
              err_illegal_next = 1'b1;
            end else if (!enc_halt && (wr_ptr_reg == LAST_SLOT)) begin
              // Only the halt slot is left; drop the record and close out.
              err_overflow_next = 1'b1;
              state_next        = S_HALT;
            end else begin
              word_next  = enc_word;
              last_next  = cmd_last;
              halt_next  = enc_halt;
              state_next = S_WRITE;
            end
          end
        end

        S_WRITE: begin
          imem_we     = 1'b1;
          imem_wdata  = word_reg;
          wr_ptr_next = wr_ptr_reg + 1'b1;
          if (AUTO_HALT && last_reg) begin
            state_next = S_HALT;
          end else if (halt_reg) begin
            state_next    = S_DONE;
            prog_len_next = wr_ptr_reg + 1'b1;
          end else begin
            state_next = S_ACCEPT;
          end
        end

        S_HALT: begin
          imem_we       = 1'b1;
          imem_wdata    = HALT_WORD;
          wr_ptr_next   = wr_ptr_reg + 1'b1;
          prog_len_next = wr_ptr_reg + 1'b1;
          state_next    = S_DONE;
        end

        S_DONE: ;

        default: state_next = S_IDLE;
      endcase
    end
  end

  assign imem_addr    = wr_ptr_reg[AW-1:0];
  assign prog_done    = (state_reg == S_DONE);
  assign prog_len     = prog_len_reg;
  assign err_illegal  = err_illegal_reg;
  assign err_overflow = err_overflow_reg;

endmodule
